gmii_rx_framer: RTL and testbench

Receive framer downstream of the RGMII RX delay stage and the DDR-to-GMII capture. Takes the 8-bit GMII receive stream (`gmii_rx_dv`, `gmii_rx_er`, `gmii_rxd`) in the RX clock domain. Strips preamble and SFD, checks FCS (CRC-32), length and `rx_er`, and presents each frame as a byte stream with last and error tags to the MAC/TCP receive path. There is no backpressure: the stream runs at line rate.

---
 rtl/gmii_rx_framer.sv | 141 ++++++++++++++
 tb/tb_gmii_rx_framer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32, length and rx_er,
// and streams each frame out with last/error tags at line rate.
module gmii_rx_framer #(
  parameter bit STRIP_FCS = 1'b1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       stat_good,
  output logic       stat_bad
);

  localparam int          D           = STRIP_FCS ? 5 : 1;
  localparam logic [15:0] D_W         = 16'(D);
  localparam logic [15:0] MIN_W       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_W       = 16'(MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state, state_nx;
  logic [3:0]  pre_cnt;
  logic [15:0] len_cnt;
  logic [31:0] crc;
  logic        err_flag;
  logic [7:0]  dly [D];
  logic        sof;
  logic        frame_end;
  logic        frame_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55)      state_nx = PRE;
          else if (gmii_rxd == 8'hD5) state_nx = DATA;
          else                        state_nx = DROP;
        end
      PRE:
        if (!gmii_rx_dv)                state_nx = IDLE;
        else if (gmii_rx_er)            state_nx = DROP;
        else if (gmii_rxd == 8'h55)     state_nx = (pre_cnt == 4'hF) ? DROP : PRE;
        else if (gmii_rxd == 8'hD5)     state_nx = DATA;
        else                            state_nx = DROP;
      DATA:
        if (!gmii_rx_dv) state_nx = IDLE;
      DROP:
        if (!gmii_rx_dv) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The residue check works because the FCS bytes go through the CRC too.
  assign sof       = (state != DATA) && (state_nx == DATA);
  assign frame_end = (state == DATA) && !gmii_rx_dv;
  assign frame_bad = (crc != CRC_RESIDUE) || err_flag ||
                     (len_cnt < MIN_W) || (len_cnt > MAX_W);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state   <= IDLE;
      pre_cnt <= 4'd0;
    end else begin
      state <= state_nx;
      if (state_nx == PRE)
        pre_cnt <= (state == PRE) ? pre_cnt + 4'd1 : 4'd1;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      len_cnt   <= 16'd0;
      crc       <= 32'hFFFFFFFF;
      err_flag  <= 1'b0;
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;
      for (int i = 0; i < D; i++) dly[i] <= 8'h00;
    end else begin
      m_tdata   <= 8'h00;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;

      if (sof) begin
        len_cnt  <= 16'd0;
        crc      <= 32'hFFFFFFFF;
        err_flag <= 1'b0;
      end

      // Bytes are held back D deep so the FCS can be withheld when stripping.
      if (state == DATA && gmii_rx_dv) begin
        crc      <= crc32_byte(crc, gmii_rxd);
        len_cnt  <= (len_cnt == 16'hFFFF) ? len_cnt : len_cnt + 16'd1;
        err_flag <= err_flag | gmii_rx_er;
        dly[0]   <= gmii_rxd;
        for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
        if (len_cnt >= D_W) begin
          m_tvalid <= 1'b1;
          m_tdata  <= dly[D-1];
        end
      end

      if (frame_end) begin
        if (len_cnt >= D_W) begin
          m_tvalid  <= 1'b1;
          m_tdata   <= dly[D-1];
          m_tlast   <= 1'b1;
          m_tuser   <= frame_bad;
          stat_good <= !frame_bad;
          stat_bad  <= frame_bad;
        end else begin
          stat_bad  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed self-checking bench for gmii_rx_framer with STRIP_FCS=1,
// MIN_LEN=64, MAX_LEN=1518.
module tb_gmii_rx_framer;

  logic       rx_clk = 1'b0;
  logic       rx_rst_n;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tuser;
  logic       stat_good;
  logic       stat_bad;

  int n_checks;
  int n_pass;
  int cyc = 0;

  logic [7:0] frm [$];
  logic [7:0] beat_data [$];
  logic       beat_last [$];
  logic       beat_user [$];
  int         good_cnt;
  int         bad_cnt;
  int         align_err;
  int         gap_err;
  int         first_beat_cyc;
  int         exp_first_cyc;
  bit         open_frame;

  gmii_rx_framer #(.STRIP_FCS(1'b1), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .rx_clk     (rx_clk),
    .rx_rst_n   (rx_rst_n),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .gmii_rxd   (gmii_rxd),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .stat_good  (stat_good),
    .stat_bad   (stat_bad)
  );

  always #4 rx_clk = ~rx_clk;

  always @(posedge rx_clk) cyc++;

  // Output monitor: captures beats and stat pulses half a cycle after each edge.
  always @(negedge rx_clk) begin
    if (m_tvalid) begin
      if (beat_data.size() == 0) first_beat_cyc = cyc;
      beat_data.push_back(m_tdata);
      beat_last.push_back(m_tlast);
      beat_user.push_back(m_tuser);
      if (m_tlast && ((stat_good !== !m_tuser) || (stat_bad !== m_tuser))) align_err++;
      open_frame = !m_tlast;
    end else if (open_frame) begin
      gap_err++;
    end
    if (stat_good) good_cnt++;
    if (stat_bad)  bad_cnt++;
  end

  // Bit-serial reference CRC (reflected, poly 0x04C11DB7).
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic int data_err(input int n);
    int lim;
    lim = (beat_data.size() < n) ? beat_data.size() : n;
    for (int i = 0; i < lim; i++)
      if (beat_data[i] !== 8'(i)) return i;
    return -1;
  endfunction

  function automatic int tlast_cnt();
    int c;
    c = 0;
    foreach (beat_last[i]) if (beat_last[i]) c++;
    return c;
  endfunction

  function automatic logic last_user();
    if (beat_user.size() == 0) return 1'bx;
    return beat_user[beat_user.size()-1];
  endfunction

  task automatic clear_mon();
    beat_data.delete();
    beat_last.delete();
    beat_user.delete();
    good_cnt       = 0;
    bad_cnt        = 0;
    align_err      = 0;
    gap_err        = 0;
    first_beat_cyc = -1;
    exp_first_cyc  = -2;
    open_frame     = 1'b0;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge rx_clk);
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic build_frame(input int npl, input logic [7:0] fcs0_xor);
    logic [31:0] c;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npl; i++) begin
      frm.push_back(8'(i));
      c = ref_crc(c, 8'(i));
    end
    c = ~c;
    frm.push_back(c[7:0] ^ fcs0_xor);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic send_frame(input int npre, input int er_idx);
    repeat (npre) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    foreach (frm[i]) begin
      drive(1'b1, (i == er_idx), frm[i]);
      if (i == 5) exp_first_cyc = cyc + 1;
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge rx_clk);
    n_checks++; if (m_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b expected 0", m_tvalid); else n_pass++;
    n_checks++; if (m_tlast !== 1'b0) $display("[TB] FAIL reset_tlast: got %b expected 0", m_tlast); else n_pass++;
    n_checks++; if (m_tuser !== 1'b0) $display("[TB] FAIL reset_tuser: got %b expected 0", m_tuser); else n_pass++;
    n_checks++; if (m_tdata !== 8'h00) $display("[TB] FAIL reset_tdata: got %h expected 00", m_tdata); else n_pass++;
    n_checks++; if (stat_good !== 1'b0) $display("[TB] FAIL reset_stat_good: got %b expected 0", stat_good); else n_pass++;
    n_checks++; if (stat_bad !== 1'b0) $display("[TB] FAIL reset_stat_bad: got %b expected 0", stat_bad); else n_pass++;
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    clear_mon();
    build_frame(60, 8'h00);
    send_frame(7, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 60) $display("[TB] FAIL good_beats: got %0d expected 60", beat_data.size()); else n_pass++;
    n_checks++; if (data_err(60) !== -1) $display("[TB] FAIL good_data: first bad beat %0d expected none", data_err(60)); else n_pass++;
    n_checks++; if (tlast_cnt() !== 1 || beat_last[beat_last.size()-1] !== 1'b1) $display("[TB] FAIL good_tlast: got %0d tlast beats expected 1 on final beat", tlast_cnt()); else n_pass++;
    n_checks++; if (last_user() !== 1'b0) $display("[TB] FAIL good_tuser: got %b expected 0", last_user()); else n_pass++;
    n_checks++; if (good_cnt !== 1) $display("[TB] FAIL good_stat_good: got %0d expected 1", good_cnt); else n_pass++;
    n_checks++; if (bad_cnt !== 0) $display("[TB] FAIL good_stat_bad: got %0d expected 0", bad_cnt); else n_pass++;
    n_checks++; if (first_beat_cyc !== exp_first_cyc) $display("[TB] FAIL good_latency: first beat cycle %0d expected %0d", first_beat_cyc, exp_first_cyc); else n_pass++;
    n_checks++; if (gap_err !== 0 || align_err !== 0) $display("[TB] FAIL good_stream: gaps %0d stat misalign %0d expected 0/0", gap_err, align_err); else n_pass++;
  endtask

  task automatic test_bad_fcs();
    clear_mon();
    build_frame(60, 8'h01);
    send_frame(7, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 60 || data_err(60) !== -1) $display("[TB] FAIL fcs_beats: got %0d beats err idx %0d expected 60/-1", beat_data.size(), data_err(60)); else n_pass++;
    n_checks++; if (last_user() !== 1'b1) $display("[TB] FAIL fcs_tuser: got %b expected 1", last_user()); else n_pass++;
    n_checks++; if (bad_cnt !== 1 || good_cnt !== 0) $display("[TB] FAIL fcs_stats: good %0d bad %0d expected 0/1", good_cnt, bad_cnt); else n_pass++;
    n_checks++; if (align_err !== 0) $display("[TB] FAIL fcs_align: got %0d misaligned expected 0", align_err); else n_pass++;
  endtask

  task automatic test_rx_er();
    clear_mon();
    build_frame(60, 8'h00);
    send_frame(7, 20);
    idle(4);
    n_checks++; if (beat_data.size() !== 60 || data_err(60) !== -1) $display("[TB] FAIL er_beats: got %0d beats err idx %0d expected 60/-1", beat_data.size(), data_err(60)); else n_pass++;
    n_checks++; if (last_user() !== 1'b1) $display("[TB] FAIL er_tuser: got %b expected 1", last_user()); else n_pass++;
    n_checks++; if (bad_cnt !== 1 || good_cnt !== 0) $display("[TB] FAIL er_stats: good %0d bad %0d expected 0/1", good_cnt, bad_cnt); else n_pass++;
  endtask

  task automatic test_runt();
    clear_mon();
    frm.delete();
    frm.push_back(8'h00);
    frm.push_back(8'h01);
    frm.push_back(8'h02);
    send_frame(7, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 0) $display("[TB] FAIL runt_beats: got %0d expected 0", beat_data.size()); else n_pass++;
    n_checks++; if (bad_cnt !== 1) $display("[TB] FAIL runt_stat_bad: got %0d expected 1", bad_cnt); else n_pass++;
    n_checks++; if (good_cnt !== 0) $display("[TB] FAIL runt_stat_good: got %0d expected 0", good_cnt); else n_pass++;
  endtask

  task automatic test_min_len();
    clear_mon();
    build_frame(59, 8'h00);
    send_frame(7, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 59 || data_err(59) !== -1) $display("[TB] FAIL minlen_beats: got %0d beats err idx %0d expected 59/-1", beat_data.size(), data_err(59)); else n_pass++;
    n_checks++; if (last_user() !== 1'b1) $display("[TB] FAIL minlen_tuser: got %b expected 1", last_user()); else n_pass++;
    n_checks++; if (bad_cnt !== 1 || good_cnt !== 0) $display("[TB] FAIL minlen_stats: good %0d bad %0d expected 0/1", good_cnt, bad_cnt); else n_pass++;
  endtask

  task automatic test_preamble_limit();
    clear_mon();
    build_frame(60, 8'h00);
    send_frame(16, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 0 || good_cnt !== 0 || bad_cnt !== 0) $display("[TB] FAIL pre16_dropped: beats %0d good %0d bad %0d expected 0/0/0", beat_data.size(), good_cnt, bad_cnt); else n_pass++;
    clear_mon();
    send_frame(15, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 60 || data_err(60) !== -1 || good_cnt !== 1) $display("[TB] FAIL pre15_accepted: beats %0d good %0d expected 60/1", beat_data.size(), good_cnt); else n_pass++;
    clear_mon();
    send_frame(0, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 60 || data_err(60) !== -1 || good_cnt !== 1) $display("[TB] FAIL pre0_accepted: beats %0d good %0d expected 60/1", beat_data.size(), good_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(60, 8'h00);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h54);
    foreach (frm[i]) drive(1'b1, 1'b0, frm[i]);
    drive(1'b0, 1'b0, 8'h00);
    send_frame(7, -1);
    idle(4);
    n_checks++; if (beat_data.size() !== 60) $display("[TB] FAIL b2b_beats: got %0d expected 60", beat_data.size()); else n_pass++;
    n_checks++; if (data_err(60) !== -1) $display("[TB] FAIL b2b_data: first bad beat %0d expected none", data_err(60)); else n_pass++;
    n_checks++; if (good_cnt !== 1 || bad_cnt !== 0) $display("[TB] FAIL b2b_stats: good %0d bad %0d expected 1/0", good_cnt, bad_cnt); else n_pass++;
    n_checks++; if (tlast_cnt() !== 1 || last_user() !== 1'b0) $display("[TB] FAIL b2b_tlast: got %0d tlast tuser %b expected 1/0", tlast_cnt(), last_user()); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int  beats_before;
    bit  nonzero_in_reset;
    clear_mon();
    build_frame(60, 8'h00);
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, frm[i]);
    drive(1'b1, 1'b0, frm[30]);
    #2 rx_rst_n = 1'b0;
    #1;
    nonzero_in_reset = ({m_tvalid, m_tlast, m_tuser, stat_good, stat_bad, m_tdata} !== 13'd0);
    beats_before = beat_data.size();
    drive(1'b1, 1'b0, frm[31]);
    if ({m_tvalid, m_tlast, m_tuser, stat_good, stat_bad, m_tdata} !== 13'd0) nonzero_in_reset = 1'b1;
    drive(1'b1, 1'b0, frm[32]);
    if ({m_tvalid, m_tlast, m_tuser, stat_good, stat_bad, m_tdata} !== 13'd0) nonzero_in_reset = 1'b1;
    drive(1'b1, 1'b0, frm[33]);
    #1 rx_rst_n = 1'b1;
    for (int i = 34; i < 64; i++) drive(1'b1, 1'b0, frm[i]);
    drive(1'b0, 1'b0, 8'h00);
    idle(4);
    n_checks++; if (nonzero_in_reset) $display("[TB] FAIL rst_outputs: got nonzero outputs during reset expected all 0"); else n_pass++;
    n_checks++; if (beats_before !== 25) $display("[TB] FAIL rst_partial_beats: got %0d expected 25", beats_before); else n_pass++;
    n_checks++; if (beat_data.size() !== 25) $display("[TB] FAIL rst_after_beats: got %0d expected 25", beat_data.size()); else n_pass++;
    n_checks++; if (tlast_cnt() !== 0 || good_cnt !== 0 || bad_cnt !== 0) $display("[TB] FAIL rst_no_tlast: tlast %0d good %0d bad %0d expected 0/0/0", tlast_cnt(), good_cnt, bad_cnt); else n_pass++;
    clear_mon();
    send_frame(7, -1);
    idle(4);
    n_checks++; if (good_cnt !== 1 || bad_cnt !== 0) $display("[TB] FAIL rst_next_stats: good %0d bad %0d expected 1/0", good_cnt, bad_cnt); else n_pass++;
    n_checks++; if (beat_data.size() !== 60 || data_err(60) !== -1) $display("[TB] FAIL rst_next_beats: got %0d beats err idx %0d expected 60/-1", beat_data.size(), data_err(60)); else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rx_rst_n   = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    clear_mon();
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rx_er();
    test_runt();
    test_min_len();
    test_preamble_limit();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
